// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline-control slice.
//   - RV opcode constants used by the internal decode
//   - canonical NOP encoding (addi x0,x0,0)
//   - forwarding-select encodings driven on fwd_a_sel / fwd_b_sel
package pipe_pkg;

   localparam logic [6:0] OPC_OP        = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_LOAD      = 7'b0000011;
   localparam logic [6:0] OPC_STORE     = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
   localparam logic [6:0] OPC_JAL       = 7'b1101111;
   localparam logic [6:0] OPC_JALR      = 7'b1100111;
   localparam logic [6:0] OPC_LUI       = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
   localparam logic [6:0] OPC_OP_32     = 7'b0111011;
   localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;

   localparam logic [31:0] NOP_ENC = 32'h0000_0013;

   localparam logic [1:0] FWD_RF    = 2'b00;
   localparam logic [1:0] FWD_EXMEM = 2'b01;
   localparam logic [1:0] FWD_MEMWB = 2'b10;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bus bundle for pipe_hazard_ctrl.
//   master (fetch/core side): drives enable, insn_in, flush; observes the rest
//   slave  (pipe_hazard_ctrl): observes enable, insn_in, flush; drives
//          insn_o, valid_o, stall_o, fwd_a_sel, fwd_b_sel, wb_en,
//          retire_cnt, stall_cnt
interface pipe_hazard_ctrl_if #(
   parameter int unsigned STAGES = 4,
   parameter int unsigned INSN_W = 32,
   parameter int unsigned CNT_W  = 32
);
   logic                       enable;
   logic [INSN_W-1:0]          insn_in;
   logic                       flush;
   logic [STAGES*INSN_W-1:0]   insn_o;
   logic [STAGES-1:0]          valid_o;
   logic                       stall_o;
   logic [1:0]                 fwd_a_sel;
   logic [1:0]                 fwd_b_sel;
   logic                       wb_en;
   logic [CNT_W-1:0]           retire_cnt;
   logic [CNT_W-1:0]           stall_cnt;

   modport master (
      output enable, insn_in, flush,
      input  insn_o, valid_o, stall_o, fwd_a_sel, fwd_b_sel, wb_en,
             retire_cnt, stall_cnt
   );

   modport slave (
      input  enable, insn_in, flush,
      output insn_o, valid_o, stall_o, fwd_a_sel, fwd_b_sel, wb_en,
             retire_cnt, stall_cnt
   );
endinterface

// File: rtl/pipe_hazard_ctrl_insn_field_decode.sv
// Opcode-only field decode of one instruction word.
//   insn      : instruction word
//   rd/rs1/rs2: raw register fields
//   writes_rd : opcode class writes a destination register
//   is_load   : LOAD opcode
//   uses_rs1  : opcode reads rs1
//   uses_rs2  : opcode reads rs2
module insn_field_decode
   import pipe_pkg::*;
(
   input  logic [31:0] insn,
   output logic [4:0]  rd,
   output logic [4:0]  rs1,
   output logic [4:0]  rs2,
   output logic        writes_rd,
   output logic        is_load,
   output logic        uses_rs1,
   output logic        uses_rs2
);
   logic [6:0] opc;

   assign opc = insn[6:0];
   assign rd  = insn[11:7];
   assign rs1 = insn[19:15];
   assign rs2 = insn[24:20];

   always_comb begin
      writes_rd = 1'b0;
      unique case (opc)
         OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_JAL, OPC_JALR,
         OPC_LUI, OPC_AUIPC, OPC_OP_32, OPC_OP_IMM_32: writes_rd = 1'b1;
         default:                                      writes_rd = 1'b0;
      endcase
      is_load  = (opc == OPC_LOAD);
      uses_rs1 = !(opc inside {OPC_JAL, OPC_LUI, OPC_AUIPC});
      uses_rs2 = (opc inside {OPC_OP, OPC_OP_32, OPC_STORE, OPC_BRANCH});
   end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline-control block: per-stage instruction/valid registers,
// load-use stall, flush with bubble insertion, EX operand forwarding
// selects, and retire/stall counters.
//   clk, srst : clock, synchronous active-high reset
//   bus       : slave side of pipe_hazard_ctrl_if (enable, insn_in, flush
//               in; insn_o, valid_o, stall_o, fwd_*_sel, wb_en, counters out)
module pipe_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int unsigned        STAGES   = 4,
   parameter int unsigned        INSN_W   = 32,
   parameter int unsigned        CNT_W    = 32,
   parameter logic [INSN_W-1:0]  NOP_INSN = INSN_W'(NOP_ENC)
)(
   input logic                clk,
   input logic                srst,
   pipe_hazard_ctrl_if.slave  bus
);
   logic [INSN_W-1:0] insn_q [STAGES];
   logic [STAGES-1:0] valid_q;
   logic [CNT_W-1:0]  retire_q;
   logic [CNT_W-1:0]  stall_q;

   // Decoded fields of IF_ID .. MEM_WB
   logic [4:0] rd_s  [4];
   logic [4:0] rs1_s [4];
   logic [4:0] rs2_s [4];
   logic       wr_s  [4];
   logic       ld_s  [4];
   logic       u1_s  [4];
   logic       u2_s  [4];

   for (genvar k = 0; k < 4; k++) begin : g_dec
      insn_field_decode u_dec (
         .insn      (insn_q[k][31:0]),
         .rd        (rd_s[k]),
         .rs1       (rs1_s[k]),
         .rs2       (rs2_s[k]),
         .writes_rd (wr_s[k]),
         .is_load   (ld_s[k]),
         .uses_rs1  (u1_s[k]),
         .uses_rs2  (u2_s[k])
      );
   end

   logic load_use;
   logic stall;
   logic ex_ok;
   logic mem_ok;

   assign load_use = valid_q[1] & ld_s[1] & (rd_s[1] != 5'd0) & valid_q[0] &
                     ((u1_s[0] & (rs1_s[0] == rd_s[1])) |
                      (u2_s[0] & (rs2_s[0] == rd_s[1])));
   // A taken flush redirects fetch anyway, so the stall is suppressed
   // for that cycle rather than holding a killed instruction.
   assign stall    = load_use & ~bus.flush;

   assign ex_ok  = valid_q[2] & wr_s[2] & (rd_s[2] != 5'd0);
   assign mem_ok = valid_q[3] & wr_s[3] & (rd_s[3] != 5'd0);

   always_comb begin
      bus.fwd_a_sel = FWD_RF;
      if (ex_ok && rd_s[2] == rs1_s[1])       bus.fwd_a_sel = FWD_EXMEM;
      else if (mem_ok && rd_s[3] == rs1_s[1]) bus.fwd_a_sel = FWD_MEMWB;
      bus.fwd_b_sel = FWD_RF;
      if (ex_ok && rd_s[2] == rs2_s[1])       bus.fwd_b_sel = FWD_EXMEM;
      else if (mem_ok && rd_s[3] == rs2_s[1]) bus.fwd_b_sel = FWD_MEMWB;
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         for (int unsigned k = 0; k < STAGES; k++) insn_q[k] <= NOP_INSN;
         valid_q  <= '0;
         retire_q <= '0;
         stall_q  <= '0;
      end else if (bus.enable) begin
         for (int unsigned k = 2; k < STAGES; k++) begin
            insn_q[k]  <= insn_q[k-1];
            valid_q[k] <= valid_q[k-1];
         end
         if (bus.flush) begin
            insn_q[0]  <= NOP_INSN;
            valid_q[0] <= 1'b0;
            insn_q[1]  <= NOP_INSN;
            valid_q[1] <= 1'b0;
         end else if (stall) begin
            insn_q[1]  <= NOP_INSN;
            valid_q[1] <= 1'b0;
         end else begin
            insn_q[1]  <= insn_q[0];
            valid_q[1] <= valid_q[0];
            insn_q[0]  <= bus.insn_in;
            valid_q[0] <= 1'b1;
         end
         if (valid_q[STAGES-1]) retire_q <= retire_q + CNT_W'(1);
         if (stall)             stall_q  <= stall_q + CNT_W'(1);
      end
   end

   always_comb begin
      bus.insn_o = '0;
      for (int unsigned k = 0; k < STAGES; k++)
         bus.insn_o[k*INSN_W +: INSN_W] = insn_q[k];
   end

   assign bus.valid_o    = valid_q;
   assign bus.stall_o    = stall;
   assign bus.wb_en      = mem_ok;
   assign bus.retire_cnt = retire_q;
   assign bus.stall_cnt  = stall_q;
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Parametrised pipeline-control block for the 5-stage RISC-V core.
- Replaces the loose chain of per-stage instruction registers with one block. Per inter-stage register (IF_ID, ID_EX, EX_MEM, MEM_WB, optional extra tail stages) it holds the instruction word and a valid bit.
- Adds load-use stall, branch/jump flush with bubble insertion, and forwarding-select generation for the EX-stage ALU operands.
- Keeps retired-instruction and stall-cycle counters for bring-up.

Parameters:
- STAGES, 4, number of pipeline registers; index 0 = IF_ID, 1 = ID_EX, 2 = EX_MEM, 3 = MEM_WB; legal range 4..8; stages >= 4 are pure delay.
- INSN_W, 32, instruction word width.
- CNT_W, 32, width of the retire and stall counters.
- NOP_INSN, 32'h00000013, word loaded into invalidated or reset stages (addi x0,x0,0).

Ports:
- clk  in  1  main clock
- srst  in  1  synchronous active-high reset
- enable  in  1  global advance; low = every register and counter holds
- insn_in  in  INSN_W  fetched instruction from instruction memory
- flush  in  1  branch/jump taken, resolved in EX; kills stages 0 and 1
- insn_o  out  STAGES*INSN_W  stage k word at bits [k*INSN_W +: INSN_W]
- valid_o  out  STAGES  per-stage valid
- stall_o  out  1  load-use stall; PC must hold
- fwd_a_sel  out  2  rs1 source for the ID_EX instruction: 00 regfile, 01 EX_MEM ALU result, 10 MEM_WB write data
- fwd_b_sel  out  2  same for rs2
- wb_en  out  1  stage 3 valid and stage-3 instruction writes rd != x0
- retire_cnt  out  CNT_W  instructions retired from stage STAGES-1
- stall_cnt  out  CNT_W  cycles with stall_o=1 and enable=1

Behaviour:
- Reset (srst=1 at posedge):
  - All valid bits = 0.
  - All instruction words = NOP_INSN.
  - Both counters = 0.
  - srst overrides enable and flush.
  - Reset mid-stall or mid-flush leaves no residue.
- Decode is internal, from the opcode only:
  - Writes rd: opcodes 0110011, 0010011, 0000011, 1101111, 1100111, 0110111, 0010111, 0111011, 0011011.
  - Is a load: 0000011.
  - Uses rs1: everything except 1101111, 0110111, 0010111.
  - Uses rs2: 0110011, 0111011, 0100011, 1100011.
- Hazard detect (combinational from registered state): stall_o = valid[1] & load(stage1) & rd1 != 0 & ((uses_rs1(stage0) & rs1_0 == rd1) | (uses_rs2(stage0) & rs2_0 == rd1)) & valid[0].
- Advance, when enable=1, priority order:
  1. flush: stage0 <= NOP, valid 0; stage1 <= NOP, valid 0; stages >= 2 shift normally.
  2. stall_o: stage0 holds; stage1 <= bubble (NOP, valid 0); stages >= 2 shift normally.
  3. Otherwise all stages shift; stage0 <= insn_in with valid 1.
  - flush together with stall: flush wins, and the stall is dropped that cycle.
- Forwarding (combinational from stage 1 sources):
  - Select 01 if valid[2], stage 2 writes rd, rd2 != 0 and rd2 == rs.
  - Else select 10 under the same test on stage 3.
  - Else 00.
  - EX_MEM has priority over MEM_WB.
  - An rs of x0 always gives 00.
  - A bubble (valid 0) never forwards.
- Counters:
  - retire_cnt increments when enable=1 and valid[STAGES-1]=1.
  - stall_cnt increments when enable=1 and stall_o=1.
  - Both wrap modulo 2^CNT_W and never saturate.
- enable=0: state frozen. stall_o and fwd_*_sel remain valid functions of the frozen state.
- Latency: insn_in to insn_o stage k = k+1 enabled cycles, absent stalls and flushes.

Decomposition:
- Shared package pipe_pkg holds:
  - RISC-V opcode constants (OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC, OPC_OP_32, OPC_OP_IMM_32).
  - NOP encoding.
  - Forward-select encodings FWD_RF=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10.
- One sub-module, insn_field_decode: combinational, instruction -> rd, rs1, rs2, writes_rd, is_load, uses_rs1, uses_rs2. Instantiated once per stage needing it.

Test Plan:
- Reset: srst=1 for 2 cycles with enable=1, then srst=0 and enable=0 → valid_o=0, every insn_o slice = 0x00000013, counters 0, stall_o=0, fwd selects 00.
- Straight line: enable=1, feed 6 independent instructions (addi x1..x6) → each appears at stage k after k+1 cycles; valid_o reaches 4'b1111; retire_cnt=3 after 7 cycles.
- Load-use stall:
  - Setup: 0x0000B283 (ld x5,0(x1)) then 0x00728333 (add x6,x5,x7).
  - Expected on the stall cycle: stall_o=1 for exactly 1 cycle; stage0 holds 0x00728333; stage1 becomes a bubble; stall_cnt=1.
  - Expected next cycle: fwd_a_sel=10 when the add reaches stage 1.
- EX forward: 0x00100293 (addi x5,x0,1) then 0x00728333 → with the add in stage 1, fwd_a_sel=01 and fwd_b_sel=00; no stall.
- Flush with stall: set up the load-use pair and assert flush on the stall cycle → stages 0 and 1 valid=0, stall_o=0 next cycle, the load continues in stage 2, and stall_cnt unchanged.
- Freeze and x0: enable=0 for 3 cycles mid-stream → insn_o, valid_o and counters unchanged. Then ld x0 followed by a consumer of x0 → no stall, fwd selects 00.
